// File: rtl/apb_slave_mem_ws.sv
// APB4 slave word memory with byte strobes,
// programmable wait states and PSLVERR.
module apb_slave_mem_ws #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_WORDS    = 0,
  parameter int ALIGN_CHK   = 1
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [AW-1:0]   PADDR,
  input  logic [DW-1:0]   PWDATA,
  input  logic [DW/8-1:0] PSTRB,
  output logic            PREADY,
  output logic            PSLVERR,
  output logic [DW-1:0]   PRDATA
);

  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] LIM    = AW'(DEPTH);
  localparam logic [AW-1:0] RO_LIM = AW'(DEPTH - RO_WORDS);
  localparam logic [AW-1:0] AMASK  = AW'(SW - 1);
  localparam logic [3:0]    WS     = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  logic              err_q;
  logic              wr_q;
  logic [IW-1:0]     idx_q;
  logic [DW-1:0]     rdata_q;
  logic [DW-1:0]     mem [DEPTH];

  logic [AW-1:0]     idx;
  logic              oor;
  logic              mis;
  logic              rov;
  logic              err;
  logic              setup;
  logic              done;

  // Address decode and error classification of the setup phase
  assign idx = PADDR >> LSB;
  assign oor = idx >= LIM;
  assign mis = (ALIGN_CHK != 0) && ((PADDR & AMASK) != '0);
  assign rov = PWRITE && (idx >= RO_LIM);
  assign err = oor | mis | rov;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d = state_q;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    setup   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          setup   = 1'b1;
        end else if (PSEL && PENABLE) begin
          PREADY  = 1'b1;
          PSLVERR = 1'b1;
        end
      end
      ACCESS: begin
        PREADY  = (cnt_q == 4'd0);
        PSLVERR = PREADY & err_q;
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE && PREADY) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!PRESETn) begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end
  end

  // Wait-state counter, loaded at setup, counts down in ACCESS
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= 4'd0;
    end else if (setup) begin
      cnt_q <= WS;
    end else if (state_q == ACCESS && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Transfer attributes captured at setup
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_q <= 1'b0;
      wr_q  <= 1'b0;
      idx_q <= '0;
    end else if (setup) begin
      err_q <= err;
      wr_q  <= PWRITE;
      idx_q <= idx[IW-1:0];
    end
  end

  // Read data fetched at setup; zero on writes and errors
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_q <= '0;
    end else if (setup) begin
      if (!PWRITE && !err) begin
        rdata_q <= mem[idx[IW-1:0]];
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign PRDATA = rdata_q;

  // Array: cleared by reset, byte-merged on good write completion
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (done && wr_q && !err_q) begin
      for (int b = 0; b < SW; b++) begin
        if (PSTRB[b]) begin
          mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Directed bench for apb_slave_mem_ws over
// several wait-state / read-only configurations.
module tb_apb_slave_mem_ws;

  logic        clk;
  logic        rst_n;
  logic        psel [4];
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready [4];
  logic        pslverr [4];
  logic [31:0] prdata [4];

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k=0: WAIT 0, RO 4 ; k=1: WAIT 3 ; k=2: WAIT 5 ; k=3: WAIT 4
  apb_slave_mem_ws #(.WAIT_CYCLES(0), .RO_WORDS(4)) d0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]),
    .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .PRDATA(prdata[0]));

  apb_slave_mem_ws #(.WAIT_CYCLES(3)) d1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]),
    .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .PRDATA(prdata[1]));

  apb_slave_mem_ws #(.WAIT_CYCLES(5)) d2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]),
    .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .PRDATA(prdata[2]));

  apb_slave_mem_ws #(.WAIT_CYCLES(4)) d3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[3]),
    .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
    .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[3]),
    .PSLVERR(pslverr[3]), .PRDATA(prdata[3]));

  // One full APB transfer; entered and left at posedge+1.
  // nw = access cycles seen with PREADY low.
  task automatic xfer(input int k, input bit wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      output logic [31:0] rd,
                      output logic er, output int nw);
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    @(posedge clk); #1;
    penable = 1'b1;
    nw = 0;
    @(negedge clk);
    while (!pready[k] && nw < 40) begin
      nw++;
      @(negedge clk);
    end
    if (!pready[k]) begin
      checks++;
      failures++;
      $display("FAIL timeout k=%0d addr=%h: no PREADY in %0d",
               k, a, nw);
    end
    rd = prdata[k];
    er = pslverr[k];
    @(posedge clk); #1;
    psel[k] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    for (int k = 0; k < 4; k++) psel[k] = 1'b0;
    #3;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 ||
          prdata[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset k=%0d got rdy=%b err=%b d=%h want 0 0 0",
                 k, pready[k], pslverr[k], prdata[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd;
    logic er;
    int nw;
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, nw);
    checks++;
    if (er !== 1'b0 || nw !== 0) begin
      failures++;
      $display("FAIL zw_write got err=%b waits=%0d want 0 0", er, nw);
    end
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || nw !== 0) begin
      failures++;
      $display("FAIL zw_read got d=%h err=%b waits=%0d want deadbeef 0 0",
               rd, er, nw);
    end
  endtask

  task automatic test_protocol();
    logic [31:0] rd;
    logic er;
    int nw;
    psel[0] = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'h0;
    pstrb   = 4'hF;
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b1 || pslverr[0] !== 1'b1) begin
      failures++;
      $display("FAIL violation got rdy=%b err=%b want 1 1",
               pready[0], pslverr[0]);
    end
    @(posedge clk); #1;
    psel[0] = 1'b0;
    penable = 1'b0;
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL violation_nowrite got d=%h err=%b want deadbeef 0",
               rd, er);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    logic er;
    int nw;
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, rd, er, nw);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, nw);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      failures++;
      $display("FAIL strobe_merge got d=%h err=%b want 11bb33dd 0",
               rd, er);
    end
    xfer(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, nw);
    checks++;
    if (er !== 1'b0) begin
      failures++;
      $display("FAIL strobe_zero_err got %b want 0", er);
    end
    xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL strobe_zero_data got %h want 11bb33dd", rd);
    end
  endtask

  task automatic test_wait3();
    logic [31:0] rd;
    logic er;
    int nw;
    xfer(1, 1, 32'h8, 32'h12345678, 4'hF, rd, er, nw);
    checks++;
    if (nw !== 3 || er !== 1'b0) begin
      failures++;
      $display("FAIL wait3_write got waits=%0d err=%b want 3 0",
               nw, er);
    end
    xfer(1, 0, 32'h8, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h12345678 || nw + 2 !== 5) begin
      failures++;
      $display("FAIL wait3_read got d=%h cycles=%0d want 12345678 5",
               rd, nw + 2);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int nw;
    xfer(0, 0, 32'h400, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL oor_read got err=%b d=%h want 1 0", er, rd);
    end
    xfer(0, 1, 32'h402, 32'h1, 4'hF, rd, er, nw);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL misalign_write got err=%b want 1", er);
    end
    xfer(0, 0, 32'h11, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL misalign_read got err=%b d=%h want 1 0", er, rd);
    end
    xfer(0, 1, 32'h3FC, 32'hFFFFFFFF, 4'hF, rd, er, nw);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL ro_write_top got err=%b want 1", er);
    end
    xfer(0, 0, 32'h3FC, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL ro_read_top got err=%b d=%h want 0 0", er, rd);
    end
    xfer(0, 1, 32'h3F0, 32'h5A5A5A5A, 4'hF, rd, er, nw);
    checks++;
    if (er !== 1'b1) begin
      failures++;
      $display("FAIL ro_write_low got err=%b want 1", er);
    end
    xfer(0, 1, 32'h3EC, 32'hCAFEF00D, 4'hF, rd, er, nw);
    xfer(0, 0, 32'h3EC, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL rw_below_ro got err=%b d=%h want 0 cafef00d",
               er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    int nw;
    int tot;
    tot = 0;
    xfer(0, 1, 32'h40, 32'hA0A0A0A0, 4'hF, rd, er, nw);
    tot += nw;
    xfer(0, 1, 32'h44, 32'hB1B1B1B1, 4'hF, rd, er, nw);
    tot += nw;
    xfer(0, 0, 32'h40, 32'h0, 4'h0, rd, er, nw);
    tot += nw;
    checks++;
    if (rd !== 32'hA0A0A0A0) begin
      failures++;
      $display("FAIL b2b_read0 got %h want a0a0a0a0", rd);
    end
    xfer(0, 0, 32'h44, 32'h0, 4'h0, rd, er, nw);
    tot += nw;
    checks++;
    if (rd !== 32'hB1B1B1B1 || tot !== 0) begin
      failures++;
      $display("FAIL b2b_read1 got d=%h waits=%0d want b1b1b1b1 0",
               rd, tot);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic er;
    int nw;
    int hi;
    hi = 0;
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h30;
    pwdata  = 32'h0BADF00D;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (pready[2]) hi++;
      @(posedge clk); #1;
    end
    psel[2] = 1'b0;
    penable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (pready[2]) hi++;
      @(posedge clk); #1;
    end
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL abort_ready got %0d high cycles want 0", hi);
    end
    xfer(2, 0, 32'h30, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h0 || nw !== 5) begin
      failures++;
      $display("FAIL abort_nowrite got d=%h waits=%0d want 0 5",
               rd, nw);
    end
    xfer(2, 1, 32'h30, 32'h0BADF00D, 4'hF, rd, er, nw);
    xfer(2, 0, 32'h30, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h0BADF00D || er !== 1'b0 || nw !== 5) begin
      failures++;
      $display("FAIL abort_next got d=%h err=%b waits=%0d want 0badf00d 0 5",
               rd, er, nw);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    int nw;
    xfer(3, 1, 32'h4, 32'h00000077, 4'hF, rd, er, nw);
    xfer(3, 0, 32'h4, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h77 || nw !== 4) begin
      failures++;
      $display("FAIL rstmid_pre got d=%h waits=%0d want 77 4", rd, nw);
    end
    psel[3] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0;
    pwdata  = 32'h55;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pready[3] !== 1'b0 || pslverr[3] !== 1'b0 ||
        prdata[3] !== 32'h0 || prdata[0] !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_out got rdy=%b err=%b d=%h want 0 0 0",
               pready[3], pslverr[3], prdata[3]);
    end
    @(posedge clk); #1;
    psel[3] = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(3, 0, 32'h0, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_word0 got d=%h err=%b want 0 0", rd, er);
    end
    xfer(3, 0, 32'h4, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_word1 got %h want 0", rd);
    end
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, nw);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_clear got %h want 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_protocol();
    test_strobe();
    test_wait3();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end

endmodule
